uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLK_HZ, 100_000_000, system clock frequency in Hz used to derive bit periods.
REQ-002 Port: clk  input  1  system clock; all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  receiver enable; low holds block in IDLE.
REQ-005 Port: baud_sel  input  2  rate select: 0=9600, 1=19200, 2=38400, 3=115200 baud.
REQ-006 Port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 Port: data  output  8  last received byte.
REQ-008 Port: valid  output  1  one-cycle pulse: data holds a good frame.
REQ-009 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port: parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; 2-cycle input latency.
REQ-013 Bit period DIV SHALL be CLK_HZ/baud (integer division), half period DIV/2; counter 16 bits wide; CLK_HZ SHALL keep DIV at 9600 below 65536.
REQ-014 baud_sel SHALL be latched on leaving IDLE; changes mid-frame have no effect until next frame.
REQ-015 FSM states: IDLE, START, DATA, [PARITY], STOP.
REQ-016 IDLE -> START on synchronized rx 1->0 edge while en=1; bit counter cleared.
REQ-017 START: after half period, sample rx; 0 -> DATA (counter restarts), 1 -> IDLE (glitch rejected, no pulse).
REQ-018 DATA: sample rx every full period, shift in LSB first; after 8th sample -> PARITY (if compiled) else STOP.
REQ-019 STOP: sample after full period; 1 -> valid pulse, 0 -> frame_err pulse; data updated in both cases on the cycle following the sample; then IDLE.
REQ-020 valid and frame_err SHALL never assert together; with parity error and good stop, parity_err pulses instead of valid.
REQ-021 From STOP, return to IDLE occurs at mid-stop-bit so a start edge immediately after is caught.
REQ-022 en deasserted in any state SHALL force IDLE next cycle, no output pulse, data unchanged.
REQ-023 rx held low (break) SHALL yield one frame_err then wait in IDLE until rx returns high before a new start edge.

Reset
REQ-024 On rst: state IDLE, data=8'h00, valid=0, frame_err=0, parity_err=0, busy=0, synchronizer=1, counters=0.
REQ-025 rst asserted mid-frame SHALL abort immediately; after release, reception resumes only on a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: defined -> one even-parity bit received after data bit 7 (PARITY state, one full period), mismatch sets parity_err per REQ-020.
REQ-027 Macro undefined -> no PARITY state, 10-bit frame, parity_err tied to 0.

Verification (CLK_HZ=100_000_000, baud_sel=3: DIV=868, half=434)
REQ-028 Byte 8'hA5, 8N1, good stop -> one valid pulse, data=8'hA5, frame_err=0, busy low after frame.
REQ-029 Byte 8'h3C with stop bit driven low -> one frame_err pulse, no valid, data=8'h3C.
REQ-030 rx low pulse of 200 cycles from idle -> START then IDLE, no pulse, data unchanged.
REQ-031 Back-to-back 8'h00 then 8'hFF with zero idle gap -> two valid pulses, data 8'h00 then 8'hFF.
REQ-032 rst asserted during bit 3 of 8'h55, released, then 8'h81 sent -> outputs reset values, then single valid with data=8'h81.
REQ-033 With UART_RX_PARITY_EN, byte 8'h01 with parity bit 0 -> parity_err pulse, no valid; parity bit 1 -> valid, data=8'h01.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- 8-bit asynchronous serial receiver with selectable baud rate.
//
// Frame: one start bit (low), eight data bits LSB first, an optional even
// parity bit, and one stop bit (high). Each bit is sampled at its centre.
// The centre is found by waiting half a bit period after the start edge, and
// then one full bit period for every bit after that.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> the frame carries one even-parity bit after
//                                   data bit 7. A parity mismatch raises
//                                   parity_err in place of valid.
//                      undefined -> 8N1 frame with no parity bit. parity_err is
//                                   tied low.
//
// Parameters:
//   CLK_HZ       system clock frequency in Hz; bit period = CLK_HZ / baud
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           receiver enable; low forces IDLE
//   baud_sel     0=9600, 1=19200, 2=38400, 3=115200; sampled at start of frame
//   rx           serial line, idle high, asynchronous to clk
//   data         last received byte (updated on good and bad stop bits)
//   valid        one-cycle pulse: data holds a good frame
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch with a good stop bit
//   busy         high whenever the FSM is not in IDLE
//   state_dbg_o  current FSM state encoding (IDLE=0 START=1 DATA=2
//                PARITY=3 STOP=4)
//
// Handshake: valid, frame_err and parity_err are single-cycle pulses with no
// back-pressure. The consumer must capture data on the cycle that valid is
// high. At most one of the three pulses is high in any cycle.

module uart_rx #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic [2:0] state_dbg_o
);

  // Bit periods in clock cycles for each selectable baud rate.
  localparam logic [15:0] DIV_9600   = 16'(CLK_HZ / 9600);
  localparam logic [15:0] DIV_19200  = 16'(CLK_HZ / 19200);
  localparam logic [15:0] DIV_38400  = 16'(CLK_HZ / 38400);
  localparam logic [15:0] DIV_115200 = 16'(CLK_HZ / 115200);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic [15:0] div_for(input logic [1:0] sel);
    logic [15:0] d;
    case (sel)
      2'd0:    d = DIV_9600;
      2'd1:    d = DIV_19200;
      2'd2:    d = DIV_38400;
      default: d = DIV_115200;
    endcase
    return d;
  endfunction

  // Synchronizer and edge-detect history. All three flops reset high so that
  // leaving reset never looks like a falling edge.
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
`ifdef UART_RX_PARITY_EN
  logic        perr_q;
  logic        par_bad_q;
`endif

  logic        fall_w;
  logic [15:0] half_m1_w;
  logic [15:0] div_m1_w;

  // A start edge is only seen as a 1->0 transition. A line held low (break)
  // therefore cannot restart the receiver until it has gone high again.
  assign fall_w    = rx_prev_q & ~rx_sync_q;
  assign half_m1_w = (div_q >> 1) - 16'd1;
  assign div_m1_w  = div_q - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      // Output pulses last one cycle unless the STOP branch sets them.
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall_w) begin
              state_q <= START;
              cnt_q   <= '0;
              bit_q   <= '0;
              // The rate is frozen for the whole frame.
              div_q   <= div_for(baud_sel);
            end
          end

          START: begin
            if (cnt_q == half_m1_w) begin
              cnt_q <= '0;
              // A line that has gone high again by mid-start is a glitch.
              state_q <= rx_sync_q ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end

          DATA: begin
            if (cnt_q == div_m1_w) begin
              cnt_q   <= '0;
              shift_q <= {rx_sync_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt_q == div_m1_w) begin
              cnt_q     <= '0;
              // Even parity: the parity bit equals the XOR of the data bits.
              par_bad_q <= (rx_sync_q != ^shift_q);
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
`endif

          STOP: begin
            if (cnt_q == div_m1_w) begin
              cnt_q  <= '0;
              data_q <= shift_q;
              if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                if (par_bad_q) perr_q <= 1'b1;
                else           valid_q <= 1'b1;
`else
                valid_q <= 1'b1;
`endif
              end else begin
                ferr_q <= 1'b1;
              end
              // The FSM leaves at mid-stop-bit so that a start edge
              // immediately after the stop bit is still caught.
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end

          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif
  assign busy        = (state_q != IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV = 868;   // 100 MHz / 115200

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] baud_sel;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Running pulse totals, written only by the monitor.
  int valid_cnt  = 0;
  int ferr_cnt   = 0;
  int perr_cnt   = 0;
  int both_cnt   = 0;
  logic [7:0] last_data = 8'h00;

  // Snapshots taken by the test tasks.
  int v0, f0, p0, b0;
  logic [7:0] d0;

  uart_rx #(.CLK_HZ(100_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .baud_sel   (baud_sel),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt = valid_cnt + 1;
        last_data = data;
      end
      if (frame_err)          ferr_cnt = ferr_cnt + 1;
      if (parity_err)         perr_cnt = perr_cnt + 1;
      if (valid && frame_err) both_cnt = both_cnt + 1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

  task automatic snap;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    b0 = both_cnt;
    d0 = data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; en = 1'b0; baud_sel = 2'd3; rx = 1'b1;
    idle(5);
    checks++; if (data !== 8'h00)      begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (state_dbg !== 3'd0)  begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
    en  = 1'b1;
    idle(20);
  endtask

  task automatic test_good_frame;
    snap();
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_data !== 8'hA5)  begin errors++; $display("FAIL a5_pulse_data: got %h want a5", last_data); end
    checks++; if (data !== 8'hA5)       begin errors++; $display("FAIL a5_data: got %h want a5", data); end
    checks++; if (ferr_cnt - f0 !== 0)  begin errors++; $display("FAIL a5_ferr_count: got %0d want 0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL a5_busy: got %b want 0", busy); end
  endtask

  task automatic test_frame_error;
    snap();
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    idle(20);
    checks++; if (ferr_cnt - f0 !== 1)  begin errors++; $display("FAIL 3c_ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL 3c_valid_count: got %0d want 0", valid_cnt - v0); end
    checks++; if (data !== 8'h3C)       begin errors++; $display("FAIL 3c_data: got %h want 3c", data); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL 3c_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    snap();
    rx = 1'b0;
    idle(10);
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL glitch_start: got state %0d want 1", state_dbg); end
    idle(190);
    rx = 1'b1;
    idle(400);
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL glitch_idle: got state %0d want 0", state_dbg); end
    checks++; if ((valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0)
      begin errors++; $display("FAIL glitch_pulses: got %0d pulses want 0", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0)); end
    checks++; if (data !== d0) begin errors++; $display("FAIL glitch_data: got %h want %h", data, d0); end
  endtask

  task automatic test_back_to_back;
    snap();
    send_frame(8'h00, 1'b1);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL b2b_first_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_data !== 8'h00)  begin errors++; $display("FAIL b2b_first_data: got %h want 00", last_data); end
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    idle(20);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_second_count: got %0d want 2", valid_cnt - v0); end
    checks++; if (last_data !== 8'hFF)  begin errors++; $display("FAIL b2b_second_data: got %h want ff", last_data); end
    checks++; if (ferr_cnt - f0 !== 0)  begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rx = b[3];
    idle(400);
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    checks++; if (data !== 8'h00)     begin errors++; $display("FAIL midrst_data: got %h want 00", data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", state_dbg); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
    rst = 1'b0;
    idle(20);
    snap();
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_81_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'h81)       begin errors++; $display("FAIL midrst_81_data: got %h want 81", data); end
    checks++; if (ferr_cnt - f0 !== 0)  begin errors++; $display("FAIL midrst_81_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_break;
    snap();
    rx = 1'b0;
    idle(12 * DIV);
    checks++; if (ferr_cnt - f0 !== 1)  begin errors++; $display("FAIL break_ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL break_valid_count: got %0d want 0", valid_cnt - v0); end
    checks++; if (data !== 8'h00)       begin errors++; $display("FAIL break_data: got %h want 00", data); end
    checks++; if (state_dbg !== 3'd0)   begin errors++; $display("FAIL break_wait_idle: got state %0d want 0", state_dbg); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL break_busy: got %b want 0", busy); end
    rx = 1'b1;
    idle(20);
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL break_release: got state %0d want 0", state_dbg); end
  endtask

  task automatic test_enable;
    snap();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    idle(300);
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL en_in_data: got state %0d want 2", state_dbg); end
    en = 1'b0;
    idle(1);
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL en_force_idle: got state %0d want 0", state_dbg); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
    rx = 1'b1;
    idle(900);
    en = 1'b1;
    idle(100);
    checks++; if ((valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0)
      begin errors++; $display("FAIL en_pulses: got %0d pulses want 0", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0)); end
    checks++; if (data !== d0) begin errors++; $display("FAIL en_data: got %h want %h", data, d0); end
  endtask

  task automatic test_baud_latch;
    logic [7:0] b;
    b = 8'h96;
    snap();
    baud_sel = 2'd3;
    send_bit(1'b0);
    baud_sel = 2'd0;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(1'b1);
    rx = 1'b1;
    idle(20);
    baud_sel = 2'd3;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL latch_valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'h96)       begin errors++; $display("FAIL latch_data: got %h want 96", data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 1; i < 8; i++) send_bit(1'b0);
    send_bit(1'b0);   // wrong: even parity of 8'h01 is 1
    send_bit(1'b1);
    rx = 1'b1;
    idle(20);
    checks++; if (perr_cnt - p0 !== 1)  begin errors++; $display("FAIL par_bad_perr: got %0d want 1", perr_cnt - p0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL par_bad_valid: got %0d want 0", valid_cnt - v0); end
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 1; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL par_good_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'h01)       begin errors++; $display("FAIL par_good_data: got %h want 01", data); end
    checks++; if (perr_cnt - p0 !== 0)  begin errors++; $display("FAIL par_good_perr: got %0d want 0", perr_cnt - p0); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; baud_sel = 2'd3; rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_enable();
    test_baud_latch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL no_parity_perr: got %0d pulses want 0", perr_cnt); end
`endif
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_ferr_together: got %0d want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
